// File: rtl/apb_xfer_ctrl.sv
// AHB-to-APB transfer sequencer: address capture, SETUP/ACCESS sequencing, slave decode and response mux.
// Optional ACCESS wait-state timeout is built in when APB_TIMEOUT_EN is defined.
module apb_xfer_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_SLV     = 12,
    parameter int SLV_SEL_LSB = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                           hclk,
    input  logic                           hreset_n,
    input  logic [ADDR_WIDTH-1:0]          haddr_int,
    input  logic                           hsel,
    input  logic                           hready,
    input  logic [1:0]                     htrans,
    input  logic                           hwrite,
    input  logic [DATA_WIDTH-1:0]          hwdata,
    output logic                           hreadyout,
    output logic                           hresp,
    output logic [DATA_WIDTH-1:0]          hrdata,
    output logic [ADDR_WIDTH-1:0]          paddr,
    output logic [NUM_SLV-1:0]             psel,
    output logic                           penable,
    output logic                           pwrite,
    output logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [NUM_SLV*DATA_WIDTH-1:0]  prdata,
    input  logic [NUM_SLV-1:0]             pready,
    input  logic [NUM_SLV-1:0]             pslverr
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [3:0]              slot_q, slot_d;

    logic                    req_s;
    logic [3:0]              new_slot_s;
    logic                    new_mapped_s;
    state_e                  req_next_s;
    logic                    accept_s;
    logic [NUM_SLV-1:0]      slot_onehot_s;
    logic                    sel_ready_s;
    logic                    sel_err_s;
    logic [DATA_WIDTH-1:0]   sel_rdata_s;
    logic                    unused_htrans0_s;

    assign req_s            = hsel & hready & htrans[1];
    assign new_slot_s       = haddr_int[SLV_SEL_LSB +: 4];
    assign new_mapped_s     = ({1'b0, new_slot_s} < 5'(NUM_SLV));
    assign req_next_s       = new_mapped_s ? ST_SETUP : ST_ERR1;
    assign unused_htrans0_s = htrans[0];

    assign paddr  = addr_q;
    assign pwrite = write_q;
    assign pwdata = hwdata;

    // Decode the captured slot and mux the selected slave's response; other slaves are masked out
    always_comb begin
        slot_onehot_s = {NUM_SLV{1'b0}};
        sel_ready_s   = 1'b0;
        sel_err_s     = 1'b0;
        sel_rdata_s   = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_SLV; i++) begin
            slot_onehot_s[i] = (slot_q == 4'(i));
            sel_ready_s      = sel_ready_s | (slot_onehot_s[i] & pready[i]);
            sel_err_s        = sel_err_s | (slot_onehot_s[i] & pslverr[i]);
            sel_rdata_s      = sel_rdata_s |
                               ({DATA_WIDTH{slot_onehot_s[i]}} & prdata[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_s;

    assign timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Wait-state counter: cleared on SETUP entry, counts ACCESS cycles without pready
    always_comb begin
        if (state_d == ST_SETUP) begin
            cnt_d = {CNT_W{1'b0}};
        end else if ((state_q == ST_ACCESS) && !sel_ready_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Wait-state counter register
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic timeout_s;
    assign timeout_s = 1'b0;
`endif

    // Sequencer next state, AHB/APB handshake outputs and address-phase capture
    always_comb begin
        state_d   = state_q;
        accept_s  = 1'b0;
        psel      = {NUM_SLV{1'b0}};
        penable   = 1'b0;
        hreadyout = 1'b0;
        hresp     = 1'b0;
        hrdata    = {DATA_WIDTH{1'b0}};
        case (state_q)
            ST_IDLE: begin
                hreadyout = 1'b1;
                accept_s  = 1'b1;
                state_d   = req_s ? req_next_s : ST_IDLE;
            end
            ST_SETUP: begin
                psel    = slot_onehot_s;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel    = slot_onehot_s;
                penable = 1'b1;
                if (sel_ready_s && sel_err_s) begin
                    hresp   = 1'b1;
                    state_d = ST_ERR1;
                end else if (sel_ready_s) begin
                    hreadyout = 1'b1;
                    hrdata    = sel_rdata_s;
                    accept_s  = 1'b1;
                    state_d   = req_s ? req_next_s : ST_IDLE;
                end else if (timeout_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ERR1: begin
                hresp   = 1'b1;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                hresp     = 1'b1;
                hreadyout = 1'b1;
                accept_s  = 1'b1;
                state_d   = req_s ? req_next_s : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        addr_d  = (accept_s && req_s) ? haddr_int  : addr_q;
        write_d = (accept_s && req_s) ? hwrite     : write_q;
        slot_d  = (accept_s && req_s) ? new_slot_s : slot_q;
    end

    // State and captured address-phase registers
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            write_q <= 1'b0;
            slot_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            slot_q  <= slot_d;
        end
    end

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Self-checking bench for apb_xfer_ctrl: directed test-plan scenarios plus randomized transfers
// against a per-transfer cycle model derived from the protocol rules.
module tb_apb_xfer_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 12;
`ifdef APB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic             hclk = 1'b0;
    logic             hreset_n = 1'b0;
    logic [AW-1:0]    haddr_int = '0;
    logic             hsel = 1'b0;
    logic             hready = 1'b1;
    logic [1:0]       htrans = 2'b00;
    logic             hwrite = 1'b0;
    logic [DW-1:0]    hwdata = '0;
    logic             hreadyout, hresp, penable, pwrite;
    logic [DW-1:0]    hrdata, pwdata;
    logic [AW-1:0]    paddr;
    logic [NS-1:0]    psel;
    logic [NS*DW-1:0] prdata = '0;
    logic [NS-1:0]    pready = '0;
    logic [NS-1:0]    pslverr = '0;

    int tests = 0;
    int fails = 0;

    always #5 hclk = ~hclk;

    apb_xfer_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .haddr_int(haddr_int), .hsel(hsel), .hready(hready),
        .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic slaves_random();
        for (int i = 0; i < NS; i++) prdata[i*DW +: DW] = $urandom;
        pready  = NS'($urandom);
        pslverr = NS'($urandom);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[15:12] = 4'($urandom_range(0, 15));
        return a;
    endfunction

    task automatic test_reset();
        hreset_n = 1'b0;
        slaves_random();
        hsel = 1'b1; htrans = 2'b10; haddr_int = 32'h0000_3004;
        #2;
        tests++;
        if ({psel, penable, hreadyout, hresp, hrdata, paddr, pwrite} !==
            {12'h000, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset: psel=%h pen=%b rdy=%b resp=%b rdata=%h paddr=%h pwrite=%b, want 000 0 1 0 0 0 0",
                     psel, penable, hreadyout, hresp, hrdata, paddr, pwrite);
        end
        hsel = 1'b0; htrans = 2'b00;
        @(negedge hclk); hreset_n = 1'b1;
        @(posedge hclk); #1;
    endtask

    // Address phase of a transfer presented while the controller is idle
    task automatic start(input string name, input logic [31:0] addr, input logic wr);
        hsel = 1'b1; hready = 1'b1; htrans = 2'b10; haddr_int = addr; hwrite = wr;
        hwdata = $urandom;
        slaves_random();
        @(negedge hclk);
        tests++;
        if ({psel, penable, hreadyout, hresp, hrdata} !== {12'h000, 1'b0, 1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL %s addr-phase: psel=%h pen=%b rdy=%b resp=%b rdata=%h, want idle/ready",
                     name, psel, penable, hreadyout, hresp, hrdata);
        end
        @(posedge hclk); #1;
    endtask

    // Data phase of one transfer; optionally presents the next address phase alongside it
    task automatic xfer(input string name, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input int waits, input logic err, input logic [31:0] rd,
                        input logic nxt_v, input logic [31:0] nxt_a, input logic nxt_w);
        int slot, ncyc;
        bit mapped;
        logic [NS-1:0] e_psel;
        logic e_pen, e_rdy, e_resp;
        logic [DW-1:0] e_rdata;
        slot   = int'(addr[15:12]);
        mapped = (slot < NS);
        ncyc   = mapped ? (waits + 2 + (err ? 2 : 0)) : 2;
        for (int c = 0; c < ncyc; c++) begin
            e_psel = '0; e_pen = 1'b0; e_rdy = 1'b0; e_resp = 1'b0; e_rdata = '0;
            if (mapped) begin
                if (c <= waits + 1) begin
                    e_psel[slot] = 1'b1;
                    e_pen = (c != 0);
                    if (c == waits + 1) begin
                        e_resp  = err;
                        e_rdy   = !err;
                        e_rdata = err ? 32'h0 : rd;
                    end
                end else begin
                    e_resp = 1'b1;
                    e_rdy  = (c == waits + 3);
                end
            end else begin
                e_resp = 1'b1;
                e_rdy  = (c == 1);
            end
            slaves_random();
            if (mapped) begin
                pready[slot] = (c == waits + 1);
                if (c == waits + 1) begin
                    pslverr[slot] = err;
                    prdata[slot*DW +: DW] = rd;
                end
            end
            hwdata = wd;
            if (nxt_v) begin
                hsel = 1'b1; htrans = 2'b10; haddr_int = nxt_a; hwrite = nxt_w;
            end else begin
                hsel = 1'($urandom); htrans = 2'($urandom_range(0, 1)); haddr_int = $urandom;
                hwrite = 1'($urandom);
            end
            @(negedge hclk);
            tests++;
            if ({psel, penable, hreadyout, hresp, hrdata} !== {e_psel, e_pen, e_rdy, e_resp, e_rdata}) begin
                fails++;
                $display("FAIL %s cyc%0d: got psel=%h pen=%b rdy=%b resp=%b rdata=%h, want psel=%h pen=%b rdy=%b resp=%b rdata=%h",
                         name, c, psel, penable, hreadyout, hresp, hrdata, e_psel, e_pen, e_rdy, e_resp, e_rdata);
            end
            if (e_psel != '0) begin
                tests++;
                if ({paddr, pwrite, pwdata} !== {addr, wr, wd}) begin
                    fails++;
                    $display("FAIL %s apb cyc%0d: got paddr=%h pwrite=%b pwdata=%h, want %h %b %h",
                             name, c, paddr, pwrite, pwdata, addr, wr, wd);
                end
            end
            @(posedge hclk); #1;
        end
    endtask

    task automatic test_idle_ignore();
        logic [3:0] combos [5];
        combos = '{4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b0111};
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                hsel = combos[k][3]; hready = combos[k][2]; htrans = combos[k][1:0];
            end else begin
                hsel = 1'b0; hready = 1'b1; htrans = 2'b00;
            end
            haddr_int = rand_addr(); hwrite = 1'($urandom);
            slaves_random();
            @(negedge hclk);
            tests++;
            if ({psel, penable, hreadyout, hresp, hrdata} !== {12'h000, 1'b0, 1'b1, 1'b0, 32'h0}) begin
                fails++;
                $display("FAIL idle_ignore k%0d: psel=%h pen=%b rdy=%b resp=%b rdata=%h, want idle/ready",
                         k, psel, penable, hreadyout, hresp, hrdata);
            end
            @(posedge hclk); #1;
        end
        hready = 1'b1;
    endtask

    task automatic test_write_slot3();
        start("wr3", 32'h0000_3004, 1'b1);
        xfer("wr3", 32'h0000_3004, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_read_waits();
        start("rd11", 32'h0000_B010, 1'b0);
        xfer("rd11", 32'h0000_B010, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_unmapped();
        start("unmap", 32'h0000_C000, 1'b0);
        xfer("unmap", 32'h0000_C000, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0);
        xfer("after_unmap", 32'h0000_0040, 1'b0, 32'h0, 1, 1'b0, 32'hCAFE_0000, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_slverr();
        start("err5", 32'h0000_5008, 1'b1);
        xfer("err5", 32'h0000_5008, 1'b1, 32'h0BAD_F00D, 1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back_reset();
        start("b2b", 32'h0000_0010, 1'b0);
        xfer("b2b0", 32'h0000_0010, 1'b0, 32'h0, 0, 1'b0, 32'h1111_0000, 1'b1, 32'h0000_1008, 1'b0);
        for (int c = 0; c < 2; c++) begin
            slaves_random();
            pready[1] = 1'b0;
            hsel = 1'b0; htrans = 2'b00;
            @(negedge hclk);
            tests++;
            if ({psel, penable, paddr} !== {12'h002, (c == 1), 32'h0000_1008}) begin
                fails++;
                $display("FAIL b2b1 cyc%0d: psel=%h pen=%b paddr=%h, want 002 %b 00001008",
                         c, psel, penable, paddr, (c == 1));
            end
            if (c == 0) begin
                @(posedge hclk); #1;
            end
        end
        hreset_n = 1'b0;
        #1;
        tests++;
        if ({psel, penable, hreadyout, hresp, hrdata, paddr, pwrite} !==
            {12'h000, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset: psel=%h pen=%b rdy=%b resp=%b rdata=%h paddr=%h pwrite=%b, want reset values",
                     psel, penable, hreadyout, hresp, hrdata, paddr, pwrite);
        end
        @(posedge hclk); #1;
        @(negedge hclk); hreset_n = 1'b1;
        @(posedge hclk); #1;
        start("post_rst", 32'h0000_0020, 1'b1);
        xfer("post_rst", 32'h0000_0020, 1'b1, 32'h5555_AAAA, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        start("tmo", 32'h0000_2000, 1'b0);
        slaves_random(); pready[2] = 1'b0;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge hclk);
        tests++;
        if ({psel, penable, hreadyout} !== {12'h004, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL tmo setup: psel=%h pen=%b rdy=%b, want 004 0 0", psel, penable, hreadyout);
        end
        @(posedge hclk); #1;
`ifdef APB_TIMEOUT_EN
        for (int c = 0; c < TO + 2; c++) begin
            slaves_random(); pready[2] = 1'b0;
            @(negedge hclk);
            tests++;
            if (c < TO) begin
                if ({psel, penable, hreadyout, hresp} !== {12'h004, 1'b1, 1'b0, 1'b0}) begin
                    fails++;
                    $display("FAIL tmo wait%0d: psel=%h pen=%b rdy=%b resp=%b, want 004 1 0 0",
                             c, psel, penable, hreadyout, hresp);
                end
            end else if ({psel, penable, hreadyout, hresp} !== {12'h000, 1'b0, (c == TO + 1), 1'b1}) begin
                fails++;
                $display("FAIL tmo err%0d: psel=%h pen=%b rdy=%b resp=%b, want 000 0 %b 1",
                         c - TO, psel, penable, hreadyout, hresp, (c == TO + 1));
            end
            @(posedge hclk); #1;
        end
`else
        for (int c = 0; c < 100; c++) begin
            slaves_random(); pready[2] = 1'b0;
            @(negedge hclk);
            tests++;
            if ({psel, penable, hreadyout, hresp} !== {12'h004, 1'b1, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL notmo wait%0d: psel=%h pen=%b rdy=%b resp=%b, want 004 1 0 0",
                         c, psel, penable, hreadyout, hresp);
            end
            @(posedge hclk); #1;
        end
        d = $urandom;
        slaves_random(); pready[2] = 1'b1; pslverr[2] = 1'b0; prdata[2*DW +: DW] = d;
        @(negedge hclk);
        tests++;
        if ({hreadyout, hresp, hrdata} !== {1'b1, 1'b0, d}) begin
            fails++;
            $display("FAIL notmo done: rdy=%b resp=%b rdata=%h, want 1 0 %h", hreadyout, hresp, hrdata, d);
        end
        @(posedge hclk); #1;
`endif
    endtask

    task automatic test_random();
        logic [31:0] a, na;
        logic w, nw;
        bit chain;
        a = rand_addr(); w = 1'($urandom);
        start("rnd", a, w);
        for (int i = 0; i < 40; i++) begin
            chain = ($urandom_range(0, 1) == 1) && (i < 39);
            na = rand_addr(); nw = 1'($urandom);
            xfer("rnd", a, w, $urandom, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom,
                 chain, na, nw);
            if (!chain && i < 39) start("rnd", na, nw);
            a = na; w = nw;
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_write_slot3();
        test_read_waits();
        test_unmapped();
        test_slverr();
        test_back_to_back_reset();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_xfer_ctrl.md
Name: apb_xfer_ctrl

Overview:
- Transfer sequencer between the AHB slave interface and the APB bus of the bridge.
- Qualifies AHB requests and captures the address phase.
- Runs the APB SETUP/ACCESS protocol and decodes one of 12 slave selects.
- Muxes slave responses back to the AHB side, including wait states and the two-cycle AHB ERROR response.

Parameters:
- ADDR_WIDTH, 32, internal AHB / APB address width
- DATA_WIDTH, 32, AHB and APB data width
- NUM_SLV, 12, number of APB slaves (max 16)
- SLV_SEL_LSB, 12, LSB of the 4-bit slot field in the address (4 KB per slave)
- TIMEOUT_CYC, 255, ACCESS wait-state limit (used only with APB_TIMEOUT_EN)

Ports:
- hclk  in  1  AHB system clock
- hreset_n  in  1  reset; asynchronous, active-low
- haddr_int  in  ADDR_WIDTH  internal AHB address
- hsel  in  1  AHB slave select
- hready  in  1  AHB bus ready
- htrans  in  2  AHB transfer type
- hwrite  in  1  AHB write/read
- hwdata  in  DATA_WIDTH  AHB write data
- hreadyout  out  1  AHB ready output
- hresp  out  1  AHB response (1 = ERROR)
- hrdata  out  DATA_WIDTH  AHB read data
- paddr  out  ADDR_WIDTH  APB address
- psel  out  NUM_SLV  one-hot APB select
- penable  out  1  APB enable
- pwrite  out  1  APB write
- pwdata  out  DATA_WIDTH  APB write data
- prdata  in  NUM_SLV*DATA_WIDTH  packed slave read data; slave i at [i*DATA_WIDTH +: DATA_WIDTH]
- pready  in  NUM_SLV  per-slave ready
- pslverr  in  NUM_SLV  per-slave error

Behaviour:
- **Reset** (hreset_n=0, asynchronous): state=IDLE, psel=0, penable=0, paddr=0, pwrite=0, hresp=0, hreadyout=1, hrdata=0, internal slot/addr registers=0. Reset mid-transfer aborts immediately; psel/penable drop in the same instant.
- **Valid request**: hsel & hready & htrans[1] (NONSEQ or SEQ). IDLE/BUSY htrans are ignored, with OKAY and zero wait.
- **Address capture**: on a valid request in a cycle where hreadyout=1, register haddr_int, hwrite and slot = haddr_int[SLV_SEL_LSB+3:SLV_SEL_LSB].
- **Slot decode**: slot < NUM_SLV selects that slave; slot >= NUM_SLV is unmapped.
- **States**: IDLE, SETUP, ACCESS, ERR1, ERR2.
  - IDLE: hreadyout=1. Mapped request -> SETUP; unmapped request -> ERR1 (no psel ever asserted).
  - SETUP: psel[slot]=1, penable=0, hreadyout=0. Always -> ACCESS.
  - ACCESS: psel[slot]=1, penable=1.
    - pready[slot]=0: hreadyout=0, stay.
    - pready[slot]=1 & pslverr[slot]=0: hreadyout=1, hresp=0, hrdata=prdata slice (combinational in this cycle). Next: SETUP on a new mapped request this cycle, ERR1 on an unmapped one, else IDLE.
    - pready[slot]=1 & pslverr[slot]=1: hreadyout=0, hresp=1 -> ERR1.
  - ERR1: hresp=1, hreadyout=0, psel=0, penable=0 -> ERR2.
  - ERR2: hresp=1, hreadyout=1. New request is captured and handled as from IDLE; else IDLE.
- **APB-side signals**:
  - paddr and pwrite hold the captured values and stay stable across SETUP/ACCESS.
  - pwdata = hwdata pass-through; the AHB master holds hwdata stable while hreadyout=0.
  - pwdata content is don't-care when psel=0.
- **hrdata** = 0 outside a successful ACCESS completion cycle.
- **Latency**: a zero-wait APB slave completes in 2 AHB data-phase cycles (SETUP + ACCESS), i.e. 1 wait state.
- **Back-to-back transfers**: no IDLE bubble on APB; psel may stay high with penable toggling 1->0 between transfers.
- **pready/pslverr** of non-selected slaves are ignored.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on SETUP entry and increments each ACCESS cycle with pready[slot]=0.
  - When the count reaches TIMEOUT_CYC: psel/penable are dropped next cycle and the transfer terminates via ERR1/ERR2.
  - pready arriving in the same cycle as the limit takes priority (normal completion).
- Not defined: no counter; ACCESS waits indefinitely.

Test Plan:
- Write 0xA5A5_0001 to 0x0000_3004, slave 3 pready=1: SETUP with psel=0x008, paddr=0x3004, pwdata=0xA5A5_0001; ACCESS penable=1; hreadyout=1, hresp=0 in the ACCESS cycle.
- Read 0x0000_B010, slave 11 inserts 3 wait states, prdata_11=0x1234_5678: hreadyout low for 4 cycles; hrdata=0x1234_5678 on completion.
- Read 0x0000_C000 (slot 12, unmapped): psel stays 0; hresp=1/hreadyout=0 then hresp=1/hreadyout=1; following access to slot 0 succeeds.
- Write to slot 5 with pslverr_5=1 at pready_5=1: two-cycle ERROR response; psel drops in ERR1.
- Back-to-back NONSEQ reads to slots 0 then 1, with hreset_n pulsed low during the second ACCESS: outputs return to reset values immediately; the next request starts cleanly from IDLE.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=8, slave 2 pready held 0: ERROR response after 8 ACCESS wait cycles. Without the macro: hreadyout stays 0 after 100 cycles.
